// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : MEM-stage load/store unit. Runs a req/ack bus access, stalls the
//            pipeline while it is in flight, and formats load data.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemWriteM,
    input  logic        ResultSrcM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] c_last = 8'(TIMEOUT - 1);

    state_t      r_state, w_next;
    logic [7:0]  r_cnt;
    logic        r_err, r_load;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic        w_access, w_illegal, w_start, w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_fmt;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_access  = MemWriteM | ResultSrcM;
    assign w_start   = (r_state == S_IDLE) & w_access & ~w_illegal;
    assign w_timeout = (r_cnt == c_last);
    assign MisalignM = w_access & w_illegal;
    assign StallM    = w_start | (r_state == S_BUSY);
    assign mem_req   = (r_state == S_BUSY);
    assign BusErrM   = (r_state == S_DONE) & r_err;

    always_comb begin
        w_illegal = 1'b0;
        w_be      = 4'b1111;
        w_wdata   = WriteDataM;
        case (Funct3M[1:0])
            2'b00: begin
                w_be    = 4'b0001 << ALUResultM[1:0];
                w_wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                w_illegal = ALUResultM[0];
                w_be      = ALUResultM[1] ? 4'b1100 : 4'b0011;
                w_wdata   = {2{WriteDataM[15:0]}};
            end
            2'b10:   w_illegal = (ALUResultM[1:0] != 2'b00);
            default: w_illegal = 1'b1;
        endcase
    end

    // Load formatting uses the offset/size latched at issue, not the live inputs
    always_comb begin
        w_byte = mem_rdata[7:0];
        case (r_off)
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            2'd3:    w_byte = mem_rdata[31:24];
            default: w_byte = mem_rdata[7:0];
        endcase
        w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_f3[1:0])
            2'b00:   w_fmt = {{24{~r_f3[2] & w_byte[7]}}, w_byte};
            2'b01:   w_fmt = {{16{~r_f3[2] & w_half[15]}}, w_half};
            default: w_fmt = mem_rdata;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_BUSY;
            S_BUSY:  if (mem_ack || w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_err     <= 1'b0;
            r_load    <= 1'b0;
            r_f3      <= 3'd0;
            r_off     <= 2'd0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
            ReadDataM <= 32'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        mem_we    <= MemWriteM;
                        r_load    <= ~MemWriteM;
                        mem_addr  <= {ALUResultM[31:2], 2'b00};
                        mem_be    <= w_be;
                        mem_wdata <= w_wdata;
                        r_f3      <= Funct3M;
                        r_off     <= ALUResultM[1:0];
                        r_cnt     <= 8'd0;
                        r_err     <= 1'b0;
                    end
                end
                S_BUSY: begin
                    // An ack on the final allowed cycle takes priority over timeout
                    if (mem_ack) begin
                        if (r_load) ReadDataM <= w_fmt;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                        if (r_load) ReadDataM <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE:  r_err <= 1'b0;
                default: r_err <= 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire
